// File: rtl/pfiform_pkg.sv
// Shared constants, state encoding and the remainder-amount helper
// for the PFIFORM job sequencer.
package pfiform_pkg;

    localparam int unsigned SAMP_W = 6;
    localparam int unsigned LANES  = 16;
    localparam int unsigned DATA_W = SAMP_W * LANES;
    localparam int unsigned AMT_W  = 4;
    localparam int unsigned LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_OUT,
        DONE
    } state_t;

    // Count-1 encoding of min(rem, amt+1); only meaningful when rem != 0.
    function automatic logic [AMT_W-1:0] amt_min(input logic [LEN_W-1:0] rem,
                                                 input logic [AMT_W-1:0] amt);
        logic [LEN_W-1:0] full;
        logic [LEN_W-1:0] cnt;
        full = LEN_W'(amt) + LEN_W'(1);
        cnt  = (rem < full) ? rem : full;
        return AMT_W'(cnt - LEN_W'(1));
    endfunction

endpackage

// File: rtl/pfiform_out_reg.sv
// One-deep output holding register; a load and a drain in the same
// cycle reload it without a bubble.
module pfiform_out_reg
    import pfiform_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic [AMT_W-1:0]  load_amt,
    input  logic              load_last,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [AMT_W-1:0]  amt,
    output logic              last
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            amt   <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            amt   <= load_amt;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/pfiform_seq.sv
// Job sequencer for the PFIFORM sample packing FIFO: paces joins and pops
// for one job descriptor and presents popped words on a ready/valid port.
module pfiform_seq
    import pfiform_pkg::*;
(
    input  logic              i_core_clk,
    input  logic              i_rx_rstn,
    input  logic              cfg_start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [AMT_W-1:0]  cfg_join_amt,
    input  logic [AMT_W-1:0]  cfg_pop_amt,
    output logic              cfg_busy,
    output logic              cfg_done,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    output logic              JoinEnable,
    input  logic              JoinPermit,
    output logic [AMT_W-1:0]  JoinAmout,
    output logic [DATA_W-1:0] JoinData,
    output logic              PopPermit,
    input  logic              PopEnable,
    output logic [AMT_W-1:0]  PopAmout,
    input  logic [DATA_W-1:0] PopData,
    output logic              dst_valid,
    input  logic              dst_ready,
    output logic [DATA_W-1:0] dst_data,
    output logic [AMT_W-1:0]  dst_amt,
    output logic              dst_last
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] join_rem;
    logic [LEN_W-1:0] pop_rem;
    logic [AMT_W-1:0] join_amt;
    logic [AMT_W-1:0] pop_amt;
    logic [AMT_W-1:0] join_enc;
    logic [AMT_W-1:0] pop_enc;
    logic [LEN_W-1:0] jcnt;
    logic [LEN_W-1:0] pcnt;
    logic             join_live;
    logic             pop_live;
    logic             join_xfer;
    logic             pop_xfer;
    logic             out_xfer;

    assign join_enc  = amt_min(join_rem, join_amt);
    assign pop_enc   = amt_min(pop_rem, pop_amt);
    assign jcnt      = LEN_W'(join_enc) + LEN_W'(1);
    assign pcnt      = LEN_W'(pop_enc) + LEN_W'(1);
    assign join_live = (state == RUN) && (join_rem != '0);
    assign pop_live  = (state == RUN) && (pop_rem != '0);
    assign join_xfer = JoinEnable && JoinPermit;
    assign pop_xfer  = PopPermit && PopEnable;
    assign out_xfer  = dst_valid && dst_ready;
    assign JoinData  = src_data;

    always_ff @(posedge i_core_clk) begin
        if (!i_rx_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the combinational handshake terms.
    always_comb begin
        state_nxt  = state;
        JoinEnable = src_valid && join_live;
        src_ready  = JoinPermit && join_live;
        JoinAmout  = join_live ? join_enc : '0;
        PopPermit  = pop_live && (!dst_valid || dst_ready);
        PopAmout   = pop_live ? pop_enc : '0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pop_xfer && (pop_rem == pcnt)) begin
                    state_nxt = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (out_xfer && dst_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job descriptor capture, remainder tracking and status flags.
    always_ff @(posedge i_core_clk) begin
        if (!i_rx_rstn) begin
            join_rem <= '0;
            pop_rem  <= '0;
            join_amt <= '0;
            pop_amt  <= '0;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            cfg_busy <= (state_nxt == RUN) || (state_nxt == WAIT_OUT);
            cfg_done <= (state_nxt == DONE);
            if ((state == IDLE) && cfg_start) begin
                join_rem <= cfg_len;
                pop_rem  <= cfg_len;
                join_amt <= cfg_join_amt;
                pop_amt  <= cfg_pop_amt;
            end else begin
                if (join_xfer) begin
                    join_rem <= join_rem - jcnt;
                end
                if (pop_xfer) begin
                    pop_rem <= pop_rem - pcnt;
                end
            end
        end
    end

    pfiform_out_reg u_out_reg (
        .clk       (i_core_clk),
        .rst_n     (i_rx_rstn),
        .load      (pop_xfer),
        .ready     (dst_ready),
        .load_data (PopData),
        .load_amt  (pop_enc),
        .load_last (pop_rem == pcnt),
        .valid     (dst_valid),
        .data      (dst_data),
        .amt       (dst_amt),
        .last      (dst_last)
    );

endmodule

// File: tb/tb_pfiform_seq.sv
// Bench for pfiform_seq: a queue model stands in for the packing FIFO and
// a table of jobs with hand-computed join/pop counts drives the sequencer.
module tb_pfiform_seq;
    import pfiform_pkg::*;

    logic              clk = 1'b0;
    logic              rstn;
    logic              cfg_start;
    logic [LEN_W-1:0]  cfg_len;
    logic [AMT_W-1:0]  cfg_join_amt;
    logic [AMT_W-1:0]  cfg_pop_amt;
    logic              cfg_busy;
    logic              cfg_done;
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] src_data;
    logic              JoinEnable;
    logic              JoinPermit;
    logic [AMT_W-1:0]  JoinAmout;
    logic [DATA_W-1:0] JoinData;
    logic              PopPermit;
    logic              PopEnable;
    logic [AMT_W-1:0]  PopAmout;
    logic [DATA_W-1:0] PopData;
    logic              dst_valid;
    logic              dst_ready;
    logic [DATA_W-1:0] dst_data;
    logic [AMT_W-1:0]  dst_amt;
    logic              dst_last;

    always #5 clk = ~clk;

    pfiform_seq dut (
        .i_core_clk   (clk),
        .i_rx_rstn    (rstn),
        .cfg_start    (cfg_start),
        .cfg_len      (cfg_len),
        .cfg_join_amt (cfg_join_amt),
        .cfg_pop_amt  (cfg_pop_amt),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_data     (src_data),
        .JoinEnable   (JoinEnable),
        .JoinPermit   (JoinPermit),
        .JoinAmout    (JoinAmout),
        .JoinData     (JoinData),
        .PopPermit    (PopPermit),
        .PopEnable    (PopEnable),
        .PopAmout     (PopAmout),
        .PopData      (PopData),
        .dst_valid    (dst_valid),
        .dst_ready    (dst_ready),
        .dst_data     (dst_data),
        .dst_amt      (dst_amt),
        .dst_last     (dst_last)
    );

    typedef struct packed {
        logic [15:0] len;
        logic [3:0]  ja;
        logic [3:0]  pa;
        logic        jstall;
        logic        sgap;
        logic        bp;
        logic        poke;
        logic [7:0]  njoin;
        logic [3:0]  last_ja;
        logic [7:0]  nword;
        logic [3:0]  last_pa;
    } vec_t;

    vec_t       vecs[8];
    int         total = 0;
    int         bad   = 0;
    logic [5:0] fq[$];
    logic [5:0] src_s;
    logic [5:0] exp_s;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Present the source word and the FIFO pop side for the current cycle.
    task automatic set_fifo_side(input bit permit, input bit svalid, input bit dready);
        logic [DATA_W-1:0] d;
        int                n;
        d = '0;
        for (int l = 0; l < int'(LANES); l++) d[l*SAMP_W +: SAMP_W] = src_s + 6'(l);
        src_data   = d;
        src_valid  = svalid;
        JoinPermit = permit;
        dst_ready  = dready;
        n          = int'(PopAmout) + 1;
        PopEnable  = (fq.size() >= n);
        d          = '0;
        if (PopEnable) for (int l = 0; l < n; l++) d[l*SAMP_W +: SAMP_W] = fq[l];
        PopData = d;
    endtask

    task automatic commit(output bit jx, output bit px, output bit ox);
        logic [5:0] junk;
        jx = JoinEnable && JoinPermit;
        px = PopPermit && PopEnable;
        ox = dst_valid && dst_ready;
        if (px) for (int l = 0; l <= int'(PopAmout); l++) junk = fq.pop_front();
        if (jx) begin
            for (int l = 0; l <= int'(JoinAmout); l++) fq.push_back(JoinData[l*SAMP_W +: SAMP_W]);
            src_s = src_s + 6'(int'(JoinAmout) + 1);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, DATA_W'(cfg_busy), '0);
        chk({tag, "_done"}, DATA_W'(cfg_done), '0);
        chk({tag, "_src_ready"}, DATA_W'(src_ready), '0);
        chk({tag, "_join_en"}, DATA_W'(JoinEnable), '0);
        chk({tag, "_pop_permit"}, DATA_W'(PopPermit), '0);
        chk({tag, "_dst_valid"}, DATA_W'(dst_valid), '0);
        chk({tag, "_dst_last"}, DATA_W'(dst_last), '0);
        chk({tag, "_dst_data"}, dst_data, '0);
        chk({tag, "_dst_amt"}, DATA_W'(dst_amt), '0);
        chk({tag, "_join_amt"}, DATA_W'(JoinAmout), '0);
        chk({tag, "_pop_amt"}, DATA_W'(PopAmout), '0);
    endtask

    task automatic run_job(input vec_t v);
        int                cyc;
        int                joins;
        int                words;
        int                reloads;
        int                jsum;
        int                psum;
        bit                jx, px, ox;
        bit                permit, svalid, dready;
        bit                done_seen, expect_done, held_v;
        logic [DATA_W-1:0] held, m, e;
        joins = 0; words = 0; reloads = 0; jsum = 0; psum = 0;
        done_seen = 1'b0; expect_done = 1'b0; held_v = 1'b0; held = '0;
        @(negedge clk);
        cfg_start    = 1'b1;
        cfg_len      = v.len;
        cfg_join_amt = v.ja;
        cfg_pop_amt  = v.pa;
        set_fifo_side(1'b1, 1'b1, 1'b1);
        #1;
        chk("start_idle_busy", DATA_W'(cfg_busy), '0);
        chk("start_idle_join", DATA_W'(JoinEnable), '0);
        @(negedge clk);
        cyc = 1;
        while (!done_seen && cyc < 400) begin
            permit = !(v.jstall && (cyc % 2 == 1));
            svalid = !(v.sgap && (cyc % 3 == 2));
            dready = !(v.bp && cyc >= 3 && cyc < 13);
            if (v.poke && cyc == 2) begin
                cfg_start = 1'b1; cfg_len = 16'd5; cfg_join_amt = 4'd0; cfg_pop_amt = 4'd0;
            end else begin
                cfg_start = 1'b0; cfg_len = 16'd7; cfg_join_amt = 4'd2; cfg_pop_amt = 4'd1;
            end
            set_fifo_side(permit, svalid, dready);
            #1;
            if (dst_valid && !dst_ready) chk("bp_pop_permit", DATA_W'(PopPermit), '0);
            if (held_v) begin
                chk("bp_valid_hold", DATA_W'(dst_valid), DATA_W'(1));
                chk("bp_data_stable", dst_data, held);
            end
            if (!src_valid) chk("join_en_no_src", DATA_W'(JoinEnable), '0);
            if (!JoinPermit) chk("src_ready_no_permit", DATA_W'(src_ready), '0);
            if (joins == int'(v.njoin) && JoinPermit) chk("src_ready_after_last", DATA_W'(src_ready), '0);
            chk("cfg_done", DATA_W'(cfg_done), DATA_W'(expect_done));
            chk("cfg_busy", DATA_W'(cfg_busy), DATA_W'(!expect_done));
            if (expect_done) done_seen = 1'b1;
            commit(jx, px, ox);
            if (jx) begin
                joins++;
                jsum += int'(JoinAmout) + 1;
                if (joins == int'(v.njoin)) chk("join_amt_last", DATA_W'(JoinAmout), DATA_W'(v.last_ja));
                else chk("join_amt", DATA_W'(JoinAmout), DATA_W'(v.ja));
            end
            if (px && ox) reloads++;
            if (ox) begin
                words++;
                psum += int'(dst_amt) + 1;
                m = '0; e = '0;
                for (int l = 0; l <= int'(dst_amt); l++) begin
                    m[l*SAMP_W +: SAMP_W] = '1;
                    e[l*SAMP_W +: SAMP_W] = exp_s + 6'(l);
                end
                chk("dst_data", dst_data & m, e);
                exp_s = exp_s + 6'(int'(dst_amt) + 1);
                chk("dst_last", DATA_W'(dst_last), DATA_W'(words == int'(v.nword)));
                if (words == int'(v.nword)) chk("dst_amt_last", DATA_W'(dst_amt), DATA_W'(v.last_pa));
                else chk("dst_amt", DATA_W'(dst_amt), DATA_W'(v.pa));
            end
            expect_done = ox && (words == int'(v.nword));
            held_v      = dst_valid && !dst_ready;
            held        = dst_data;
            @(negedge clk);
            cyc++;
        end
        if (!done_seen) chk("job_timeout", '0, DATA_W'(1));
        chk("join_count", DATA_W'(joins), DATA_W'(v.njoin));
        chk("word_count", DATA_W'(words), DATA_W'(v.nword));
        chk("join_total", DATA_W'(jsum), DATA_W'(v.len));
        chk("pop_total", DATA_W'(psum), DATA_W'(v.len));
        chk("fifo_drained", DATA_W'(fq.size()), '0);
        if (v.bp) chk("reload_seen", DATA_W'(reloads > 0), DATA_W'(1));
    endtask

    initial begin
        bit jx, px, ox;
        rstn = 1'b0; cfg_start = 1'b0; cfg_len = '0; cfg_join_amt = '0; cfg_pop_amt = '0;
        src_valid = 1'b0; src_data = '0; JoinPermit = 1'b0; PopEnable = 1'b0; PopData = '0;
        dst_ready = 1'b0;
        src_s = '0; exp_s = '0;
        vecs[0] = '{len:16'd48,  ja:4'd15, pa:4'd11, jstall:1'b0, sgap:1'b0, bp:1'b0, poke:1'b0,
                    njoin:8'd3, last_ja:4'd15, nword:8'd4, last_pa:4'd11};
        vecs[1] = '{len:16'd40,  ja:4'd15, pa:4'd11, jstall:1'b0, sgap:1'b0, bp:1'b0, poke:1'b1,
                    njoin:8'd3, last_ja:4'd7,  nword:8'd4, last_pa:4'd3};
        vecs[2] = '{len:16'd48,  ja:4'd15, pa:4'd11, jstall:1'b0, sgap:1'b0, bp:1'b1, poke:1'b0,
                    njoin:8'd3, last_ja:4'd15, nword:8'd4, last_pa:4'd11};
        vecs[3] = '{len:16'd40,  ja:4'd15, pa:4'd11, jstall:1'b1, sgap:1'b1, bp:1'b0, poke:1'b0,
                    njoin:8'd3, last_ja:4'd7,  nword:8'd4, last_pa:4'd3};
        vecs[4] = '{len:16'd5,   ja:4'd3,  pa:4'd1,  jstall:1'b1, sgap:1'b0, bp:1'b0, poke:1'b0,
                    njoin:8'd2, last_ja:4'd0,  nword:8'd3, last_pa:4'd0};
        vecs[5] = '{len:16'd1,   ja:4'd0,  pa:4'd0,  jstall:1'b0, sgap:1'b0, bp:1'b0, poke:1'b0,
                    njoin:8'd1, last_ja:4'd0,  nword:8'd1, last_pa:4'd0};
        vecs[6] = '{len:16'd100, ja:4'd15, pa:4'd15, jstall:1'b0, sgap:1'b1, bp:1'b1, poke:1'b0,
                    njoin:8'd7, last_ja:4'd3,  nword:8'd7, last_pa:4'd3};
        vecs[7] = '{len:16'd17,  ja:4'd7,  pa:4'd15, jstall:1'b0, sgap:1'b0, bp:1'b0, poke:1'b0,
                    njoin:8'd3, last_ja:4'd0,  nword:8'd2, last_pa:4'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        set_fifo_side(1'b1, 1'b1, 1'b1);
        #1;
        check_reset("por");
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) run_job(vecs[i]);

        // Zero-length job: straight to DONE, no handshakes.
        @(negedge clk);
        cfg_start = 1'b1; cfg_len = '0; cfg_join_amt = 4'd15; cfg_pop_amt = 4'd11;
        set_fifo_side(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        chk("len0_done", DATA_W'(cfg_done), DATA_W'(1));
        chk("len0_busy", DATA_W'(cfg_busy), '0);
        chk("len0_join_en", DATA_W'(JoinEnable), '0);
        chk("len0_pop_permit", DATA_W'(PopPermit), '0);
        @(negedge clk);
        #1;
        chk("len0_done_clear", DATA_W'(cfg_done), '0);
        chk("len0_join_en2", DATA_W'(JoinEnable), '0);

        // Reset in the middle of a running job.
        @(negedge clk);
        cfg_start = 1'b1; cfg_len = 16'd48; cfg_join_amt = 4'd15; cfg_pop_amt = 4'd11;
        set_fifo_side(1'b1, 1'b1, 1'b1);
        #1 commit(jx, px, ox);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            set_fifo_side(1'b1, 1'b1, 1'b1);
            #1 commit(jx, px, ox);
        end
        chk("pre_rst_busy", DATA_W'(cfg_busy), DATA_W'(1));
        @(negedge clk);
        rstn = 1'b0;
        set_fifo_side(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        fq.delete();
        src_s = '0;
        exp_s = '0;
        set_fifo_side(1'b1, 1'b1, 1'b1);
        #1;
        check_reset("rst_mid");
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_fifo_side(1'b1, 1'b1, 1'b1);
            #1;
            chk("post_rst_no_done", DATA_W'(cfg_done), '0);
            chk("post_rst_idle", DATA_W'(cfg_busy), '0);
        end
        run_job(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
